term_config_loader: RTL
=======================

# term_config_loader

Configuration-word loader that sits directly upstream of a tile switch matrix and drives its `ConfigBits` vector. It accepts fixed-width configuration words over a valid/ready handshake and assembles them into a staging buffer. Once the full vector has arrived, it commits the whole vector to the switch matrix in a single cycle, so routing never sees a half-written configuration. It sits between the fabric's frame/bitstream distribution logic and each tile's switch matrix, including terminal tiles.

## Interface
Parameters:
- `NoConfigBits`, default 40: width of the switch-matrix configuration vector; legal range ≥1.
- `WORD_WIDTH`, default 32: width of an incoming configuration word.
- Derived `NUM_WORDS` = ceil(`NoConfigBits`/`WORD_WIDTH`): words per full load.

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `WordData`  in  `WORD_WIDTH`  configuration word.
- `WordValid`  in  1  `WordData` is valid.
- `WordReady`  out  1  loader can accept a word this cycle.
- `ConfigAbort`  in  1  discard the partial load.
- `ConfigBits`  out  `NoConfigBits`  committed configuration to the switch matrix.
- `ConfigDone`  out  1  one-cycle pulse after each commit.
- `Busy`  out  1  a load is in progress or a commit is pending.

## Operation
- States:
  - IDLE: word count = 0.
  - LOAD: 0 < count < `NUM_WORDS`.
  - COMMIT: one cycle.
- A word is accepted on an edge where `WordValid` && `WordReady`.
  - On acceptance, the staging buffer (`NUM_WORDS`×`WORD_WIDTH` bits) shifts left by `WORD_WIDTH` and `WordData` enters the LSBs.
  - The count then increments.
- The first word received ends up most significant.
- Padding: only the low `NoConfigBits` of the buffer are committed. The excess upper bits of the first word are ignored.
- Accepting word number `NUM_WORDS` moves the FSM to COMMIT.
- In COMMIT:
  - `ConfigBits` is loaded from buffer[`NoConfigBits`-1:0].
  - The count clears.
  - The FSM returns to IDLE.
- `WordReady` = (state != COMMIT) && !`ConfigAbort`. It is low during reset.
- `ConfigAbort` in IDLE/LOAD:
  - Clears the count and returns the FSM to IDLE.
  - The buffer contents become don't-care.
  - `ConfigBits` is unchanged.
- `ConfigAbort` in COMMIT is ignored; the commit completes.
- `ConfigAbort` and `WordValid` together: abort wins and the word is not accepted.
- `ConfigBits` changes only on a commit edge or in reset. It never shows partial data.
- `Busy` = (count != 0) || (state == COMMIT).
- Back-to-back loads: a word may be accepted the first cycle after COMMIT.

## Timing
- Reset values (at the edge with `resetn`=0):
  - `ConfigBits` = all zeros, so every mux selects input 0 (safe default).
  - `ConfigDone` = 0, `Busy` = 0, `WordReady` = 0.
  - FSM = IDLE, count = 0.
- `WordReady` = 1 from the first cycle after `resetn` rises.
- Reset mid-load or mid-commit: the partial load is lost and `ConfigBits` returns to zero.
- Commit timing, with the last word accepted at edge k:
  - COMMIT occupies the cycle between edges k and k+1, and `WordReady` = 0 during it.
  - `ConfigBits` takes the new value at edge k+1.
  - `ConfigDone` is high for exactly the cycle between k+1 and k+2.
- Minimum load time is `NUM_WORDS`+1 cycles. Sustained throughput is `NUM_WORDS` words per `NUM_WORDS`+1 cycles.
- All outputs are registered except `WordReady`, which is combinational only from state and `ConfigAbort`.

## Configuration
- Macro `TERM_CFG_PARITY_EN`.
- When defined, two ports are added:
  - `WordParity` (in, 1): even parity over `WordData`.
  - `ParityErr` (out, 1): sticky error flag; reset value 0.
- On an accepted word whose parity mismatches:
  - The word is consumed.
  - The load aborts exactly as for `ConfigAbort`.
  - `ParityErr` is set and stays set until `resetn`.
  - No commit occurs.
- When undefined, neither port exists and no parity checking is performed.

## Test plan
All scenarios use `NoConfigBits`=40 and `WORD_WIDTH`=32.
- Reset:
  - Stimulus: hold `resetn`=0 for 2 cycles, then release.
  - Response: `ConfigBits`=40'h0, `ConfigDone`=0 and `Busy`=0; `WordReady` rises on the first cycle after release.
- Basic load:
  - Stimulus: send 32'h123456AB then 32'hDEADBEEF on consecutive cycles.
  - Response: `WordReady`=0 for one cycle, then `ConfigBits`=40'hAB_DEADBEEF with a one-cycle `ConfigDone`.
- Backpressure and gaps:
  - Stimulus: insert idle cycles between words, and hold `WordValid` during COMMIT.
  - Response: exactly 2 words accepted per load; the word held during COMMIT is accepted the next cycle as the first word of the next load.
- Abort:
  - Stimulus: send 32'h11111111, then assert `ConfigAbort` together with `WordValid`.
  - Response: the word is not accepted, `Busy`=0 and `ConfigBits` keeps its old value.
  - Stimulus: then send a fresh 2-word load.
  - Response: that load commits correctly.
- Reset mid-load:
  - Stimulus: pulse `resetn` low after the first word.
  - Response: `ConfigBits`=0, count=0, and no `ConfigDone` pulse.
- Parity (only with `TERM_CFG_PARITY_EN`):
  - Stimulus: send 32'h00000001 with `WordParity`=0.
  - Response: `ParityErr`=1, no commit and `Busy`=0.

Source files
------------

// File: rtl/term_config_loader_if.sv
// Word handshake between the bitstream distribution logic and a tile's config loader.
// WordParity exists only when TERM_CFG_PARITY_EN is defined.
interface term_config_loader_if #(
    parameter int unsigned WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] WordData;
    logic                  WordValid;
    logic                  WordReady;
    logic                  ConfigAbort;
`ifdef TERM_CFG_PARITY_EN
    logic                  WordParity;
`endif

    modport master (
        output WordData,
        output WordValid,
        output ConfigAbort,
`ifdef TERM_CFG_PARITY_EN
        output WordParity,
`endif
        input  WordReady
    );

    modport slave (
        input  WordData,
        input  WordValid,
        input  ConfigAbort,
`ifdef TERM_CFG_PARITY_EN
        input  WordParity,
`endif
        output WordReady
    );
endinterface

// File: rtl/term_config_loader.sv
// Assembles configuration words into a staging buffer and commits the full vector atomically.
// Optional word parity checking is enabled by defining TERM_CFG_PARITY_EN.
module term_config_loader #(
    parameter int unsigned NoConfigBits = 40,
    parameter int unsigned WORD_WIDTH   = 32
) (
    input  logic                    CLK,
    input  logic                    resetn,
    term_config_loader_if.slave     bus,
    output logic [NoConfigBits-1:0] ConfigBits,
    output logic                    ConfigDone,
`ifdef TERM_CFG_PARITY_EN
    output logic                    ParityErr,
`endif
    output logic                    Busy
);
    localparam int unsigned NUM_WORDS = (NoConfigBits + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_next;
    logic [NoConfigBits-1:0] buffer;
    logic                    accept_c;
    logic                    word_err_c;

    // State register
    always_ff @(posedge CLK) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state and word-count logic
    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            COMMIT: begin
                state_next = IDLE;
                count_next = '0;
            end
            default: begin
                if (bus.ConfigAbort || word_err_c) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (accept_c) begin
                    count_next = count + CNT_W'(1);
                    state_next = (count == CNT_W'(NUM_WORDS - 1)) ? COMMIT : LOAD;
                end
            end
        endcase
    end

    // Handshake outputs; ready is held low while reset is asserted
    always_comb begin
        bus.WordReady = resetn && (state != COMMIT) && !bus.ConfigAbort;
        accept_c      = bus.WordValid && bus.WordReady;
`ifdef TERM_CFG_PARITY_EN
        word_err_c    = accept_c && (^{bus.WordData, bus.WordParity});
`else
        word_err_c    = 1'b0;
`endif
    end

    // Only the low NoConfigBits of the shifted buffer are kept; excess first-word bits fall off
    always_ff @(posedge CLK) begin
        if (accept_c) buffer <= NoConfigBits'({buffer, bus.WordData});
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            count      <= '0;
            ConfigBits <= '0;
            ConfigDone <= 1'b0;
            Busy       <= 1'b0;
`ifdef TERM_CFG_PARITY_EN
            ParityErr  <= 1'b0;
`endif
        end else begin
            count      <= count_next;
            ConfigDone <= (state == COMMIT);
            Busy       <= (state_next == COMMIT) || (count_next != '0);
            if (state == COMMIT) ConfigBits <= buffer;
`ifdef TERM_CFG_PARITY_EN
            if (word_err_c) ParityErr <= 1'b1;
`endif
        end
    end
endmodule
